// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with true-LRU replacement, per-entry
// saturating direction counters and saturating lookup/hit statistics.
module btb_assoc #(
  parameter int unsigned WAYS       = 2,
  parameter int unsigned SETS       = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned CTR_BITS   = 2,
  parameter int unsigned STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lookup_valid,
  input  logic [ADDR_WIDTH-1:0] lookup_pc,
  output logic                  pred_hit,
  output logic [ADDR_WIDTH-1:0] pred_target,
  output logic                  pred_taken,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_pc,
  input  logic                  wb_taken,
  input  logic [ADDR_WIDTH-1:0] wb_target,
  input  logic                  invalidate,
  output logic [STAT_WIDTH-1:0] stat_lookups,
  output logic [STAT_WIDTH-1:0] stat_hits
);

  localparam int unsigned IDX_BITS = $clog2(SETS);
  localparam int unsigned TAG_W    = ADDR_WIDTH - IDX_BITS - 1;
  localparam int unsigned AGE_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [AGE_W-1:0]    AGE_LRU  = AGE_W'(WAYS - 1);

  logic                  valid_q  [SETS][WAYS];
  logic [TAG_W-1:0]      tag_q    [SETS][WAYS];
  logic [ADDR_WIDTH-1:0] target_q [SETS][WAYS];
  logic [CTR_BITS-1:0]   ctr_q    [SETS][WAYS];
  logic [AGE_W-1:0]      age_q    [SETS][WAYS];

  logic [IDX_BITS-1:0] lk_idx, wb_idx;
  logic [TAG_W-1:0]    lk_tag, wb_tag;
  logic                unused_pc_lsbs;

  assign lk_idx = lookup_pc[IDX_BITS:1];
  assign lk_tag = lookup_pc[ADDR_WIDTH-1:IDX_BITS+1];
  assign wb_idx = wb_pc[IDX_BITS:1];
  assign wb_tag = wb_pc[ADDR_WIDTH-1:IDX_BITS+1];
  assign unused_pc_lsbs = lookup_pc[0] ^ wb_pc[0];

  // Fetch-side lookup; the lowest matching way wins.
  logic lk_msb;
  always_comb begin
    pred_hit    = 1'b0;
    pred_target = '0;
    lk_msb      = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!pred_hit && valid_q[lk_idx][w] && tag_q[lk_idx][w] == lk_tag) begin
        pred_hit    = 1'b1;
        pred_target = target_q[lk_idx][w];
        lk_msb      = ctr_q[lk_idx][w][CTR_BITS-1];
      end
    end
  end
  assign pred_taken = pred_hit & lk_msb;

  // Writeback-side way selection: hit way, or victim for allocation.
  logic             wb_hit, inv_found;
  logic [AGE_W-1:0] hit_way, victim_way, touch_way, touch_age;
  always_comb begin
    wb_hit     = 1'b0;
    hit_way    = '0;
    inv_found  = 1'b0;
    victim_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!wb_hit && valid_q[wb_idx][w] && tag_q[wb_idx][w] == wb_tag) begin
        wb_hit  = 1'b1;
        hit_way = AGE_W'(w);
      end
      if (!inv_found && !valid_q[wb_idx][w]) begin
        inv_found  = 1'b1;
        victim_way = AGE_W'(w);
      end
    end
    if (!inv_found) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (age_q[wb_idx][w] == AGE_LRU) victim_way = AGE_W'(w);
      end
    end
    touch_way = wb_hit ? hit_way : victim_way;
    touch_age = age_q[wb_idx][touch_way];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          valid_q[s][w]  <= 1'b0;
          tag_q[s][w]    <= '0;
          target_q[s][w] <= '0;
          ctr_q[s][w]    <= '0;
          age_q[s][w]    <= AGE_W'(w);
        end
      end
      stat_lookups <= '0;
      stat_hits    <= '0;
    end else begin
      if (lookup_valid && stat_lookups != '1)
        stat_lookups <= stat_lookups + STAT_WIDTH'(1);
      if (lookup_valid && pred_hit && stat_hits != '1)
        stat_hits <= stat_hits + STAT_WIDTH'(1);

      if (invalidate) begin
        for (int unsigned s = 0; s < SETS; s++)
          for (int unsigned w = 0; w < WAYS; w++)
            valid_q[s][w] <= 1'b0;
      end else if (wb_valid && (wb_hit || wb_taken)) begin
        if (wb_hit) begin
          if (wb_taken) begin
            target_q[wb_idx][hit_way] <= wb_target;
            if (ctr_q[wb_idx][hit_way] != CTR_MAX)
              ctr_q[wb_idx][hit_way] <= ctr_q[wb_idx][hit_way] + CTR_BITS'(1);
          end else if (ctr_q[wb_idx][hit_way] != '0) begin
            ctr_q[wb_idx][hit_way] <= ctr_q[wb_idx][hit_way] - CTR_BITS'(1);
          end
        end else begin
          valid_q[wb_idx][victim_way]  <= 1'b1;
          tag_q[wb_idx][victim_way]    <= wb_tag;
          target_q[wb_idx][victim_way] <= wb_target;
          ctr_q[wb_idx][victim_way]    <= CTR_WEAK;
        end
        // Younger ways shift one step older so ages stay a permutation.
        for (int unsigned w = 0; w < WAYS; w++) begin
          if (AGE_W'(w) == touch_way)
            age_q[wb_idx][w] <= '0;
          else if (age_q[wb_idx][w] < touch_age)
            age_q[wb_idx][w] <= age_q[wb_idx][w] + AGE_W'(1);
        end
      end
    end
  end

endmodule
